// File: rtl/unified_ram_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction-fetch and data requesters.
// Data wins by default; a saturating streak counter forces an instruction grant when fetch is starved.
module unified_ram_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int RAM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset_,

  input  logic                    inst_req,
  input  logic [DATA_WIDTH/8-1:0] inst_write_strobe,
  input  logic [ADDR_WIDTH-1:0]   inst_address,
  input  logic [DATA_WIDTH-1:0]   inst_write_data,
  output logic                    inst_addr_ok,
  output logic                    inst_data_ok,
  output logic [DATA_WIDTH-1:0]   inst_read_data,

  input  logic                    data_req,
  input  logic [DATA_WIDTH/8-1:0] data_write_strobe,
  input  logic [ADDR_WIDTH-1:0]   data_address,
  input  logic [DATA_WIDTH-1:0]   data_write_data,
  output logic                    data_addr_ok,
  output logic                    data_data_ok,
  output logic [DATA_WIDTH-1:0]   data_read_data,

  output logic                    ram_enabled,
  output logic [DATA_WIDTH/8-1:0] ram_write_strobe,
  output logic [ADDR_WIDTH-1:0]   ram_address,
  output logic [DATA_WIDTH-1:0]   ram_write_data,
  input  logic [DATA_WIDTH-1:0]   ram_read_data
);

  localparam int STRB_WIDTH   = DATA_WIDTH / 8;
  localparam int STREAK_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(STARVE_LIMIT);
  localparam logic [STREAK_WIDTH-1:0] STREAK_ONE = STREAK_WIDTH'(1);

  logic [STREAK_WIDTH-1:0] streak_q, streak_d;
  logic [RAM_LATENCY-1:0]  vld_q, vld_d;
  logic [RAM_LATENCY-1:0]  src_q, src_d;   // 1 = data requester, 0 = instruction requester

  logic inst_starved;
  logic grant_data;
  logic grant_inst;
  logic grant_any;

  // Grants are gated by reset_ so nothing is accepted while reset is held.
  always_comb begin
    inst_starved = inst_req && (streak_q == STREAK_MAX);
    grant_data   = reset_ && data_req && !inst_starved;
    grant_inst   = reset_ && inst_req && !grant_data;
    grant_any    = grant_data || grant_inst;
  end

  always_comb begin
    ram_enabled      = grant_any;
    ram_write_strobe = '0;
    ram_address      = '0;
    ram_write_data   = '0;
    if (grant_data) begin
      ram_write_strobe = data_write_strobe;
      ram_address      = data_address;
      ram_write_data   = data_write_data;
    end else if (grant_inst) begin
      ram_write_strobe = inst_write_strobe;
      ram_address      = inst_address;
      ram_write_data   = inst_write_data;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (grant_inst || !inst_req) begin
      streak_d = '0;
    end else if (grant_data && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAK_ONE;
    end
  end

  // Stage 0 is loaded on grant; the tail stage lines up with valid ram_read_data.
  always_comb begin
    vld_d    = '0;
    src_d    = '0;
    vld_d[0] = grant_any;
    src_d[0] = grant_data;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      src_d[i] = src_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      streak_q <= '0;
      vld_q    <= '0;
      src_q    <= '0;
    end else begin
      streak_q <= streak_d;
      vld_q    <= vld_d;
      src_q    <= src_d;
    end
  end

  always_comb begin
    inst_addr_ok   = grant_inst;
    data_addr_ok   = grant_data;
    inst_data_ok   = vld_q[RAM_LATENCY-1] && !src_q[RAM_LATENCY-1];
    data_data_ok   = vld_q[RAM_LATENCY-1] &&  src_q[RAM_LATENCY-1];
    inst_read_data = ram_read_data;
    data_read_data = ram_read_data;
  end

  logic unused_strb;
  assign unused_strb = (STRB_WIDTH == 0);

endmodule

// File: tb/tb_unified_ram_arbiter.sv
// Directed bench: two arbiter instances (RAM latency 1 and 3) with behavioural RAMs and a response scoreboard.
module tb_unified_ram_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_;

  logic        a_inst_req, a_data_req, a_inst_addr_ok, a_inst_data_ok, a_data_addr_ok, a_data_data_ok, a_ram_en;
  logic [3:0]  a_inst_ws, a_data_ws, a_ram_ws;
  logic [31:0] a_inst_addr, a_inst_wd, a_data_addr, a_data_wd, a_inst_rd, a_data_rd, a_ram_addr, a_ram_wd, a_ram_rd;
  logic        b_inst_req, b_data_req, b_inst_addr_ok, b_inst_data_ok, b_data_addr_ok, b_data_data_ok, b_ram_en;
  logic [3:0]  b_inst_ws, b_data_ws, b_ram_ws;
  logic [31:0] b_inst_addr, b_inst_wd, b_data_addr, b_data_wd, b_inst_rd, b_data_rd, b_ram_addr, b_ram_wd, b_ram_rd;

  unified_ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_LATENCY(1), .STARVE_LIMIT(4)) u_a (
    .clock(clock), .reset_(reset_),
    .inst_req(a_inst_req), .inst_write_strobe(a_inst_ws), .inst_address(a_inst_addr),
    .inst_write_data(a_inst_wd), .inst_addr_ok(a_inst_addr_ok), .inst_data_ok(a_inst_data_ok),
    .inst_read_data(a_inst_rd),
    .data_req(a_data_req), .data_write_strobe(a_data_ws), .data_address(a_data_addr),
    .data_write_data(a_data_wd), .data_addr_ok(a_data_addr_ok), .data_data_ok(a_data_data_ok),
    .data_read_data(a_data_rd),
    .ram_enabled(a_ram_en), .ram_write_strobe(a_ram_ws), .ram_address(a_ram_addr),
    .ram_write_data(a_ram_wd), .ram_read_data(a_ram_rd)
  );

  unified_ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_LATENCY(3), .STARVE_LIMIT(4)) u_b (
    .clock(clock), .reset_(reset_),
    .inst_req(b_inst_req), .inst_write_strobe(b_inst_ws), .inst_address(b_inst_addr),
    .inst_write_data(b_inst_wd), .inst_addr_ok(b_inst_addr_ok), .inst_data_ok(b_inst_data_ok),
    .inst_read_data(b_inst_rd),
    .data_req(b_data_req), .data_write_strobe(b_data_ws), .data_address(b_data_addr),
    .data_write_data(b_data_wd), .data_addr_ok(b_data_addr_ok), .data_data_ok(b_data_data_ok),
    .data_read_data(b_data_rd),
    .ram_enabled(b_ram_en), .ram_write_strobe(b_ram_ws), .ram_address(b_ram_addr),
    .ram_write_data(b_ram_wd), .ram_read_data(b_ram_rd)
  );

  typedef struct {
    bit          src;   // 1 = data side
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } resp_t;

  resp_t qa[$];
  resp_t qb[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;

  logic [31:0] ram_a [256];
  bit          wa_a  [256];
  logic [31:0] exp_a [256];
  bit          ew_a  [256];
  logic [31:0] a_rd_q;
  logic [31:0] b_p0, b_p1, b_p2;

  function automatic logic [7:0] idx(input logic [31:0] a);
    return {a[13:12], a[7:2]};
  endfunction

  function automatic logic [31:0] pat(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'hDEAD_BEEF;
      32'h0000_3000: return 32'hA5A5_A5A5;
      default:       return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (st[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ram_rd_a(input logic [31:0] a);
    return wa_a[idx(a)] ? ram_a[idx(a)] : pat(a);
  endfunction

  function automatic logic [31:0] expect_rd(input bit sel, input logic [31:0] a);
    if (!sel && ew_a[idx(a)]) return exp_a[idx(a)];
    return pat(a);
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural RAMs: read-before-write, fixed latency
  always @(posedge clock) begin
    if (a_ram_en) begin
      a_rd_q <= ram_rd_a(a_ram_addr);
      if (a_ram_ws != 4'h0) begin
        ram_a[idx(a_ram_addr)] <= merge(ram_rd_a(a_ram_addr), a_ram_wd, a_ram_ws);
        wa_a[idx(a_ram_addr)]  <= 1'b1;
      end
    end
  end
  assign a_ram_rd = a_rd_q;

  always @(posedge clock) begin
    b_p0 <= b_ram_en ? pat(b_ram_addr) : 32'h0;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_ram_rd = b_p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    resp_t e;
    if (a_inst_data_ok || a_data_data_ok) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_data_ok", {30'd0, a_inst_data_ok, a_data_data_ok}, 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_resp_side", {30'd0, a_inst_data_ok, a_data_data_ok}, e.src ? 32'd1 : 32'd2);
        chk("a_resp_cycle", 32'(cyc), 32'(e.cyc));
        if (e.rd) chk("a_rdata", e.src ? a_data_rd : a_inst_rd, e.data);
      end
    end
  end

  always @(negedge clock) begin
    resp_t e;
    if (b_inst_data_ok || b_data_data_ok) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_data_ok", {30'd0, b_inst_data_ok, b_data_data_ok}, 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_resp_side", {30'd0, b_inst_data_ok, b_data_data_ok}, e.src ? 32'd1 : 32'd2);
        chk("b_resp_cycle", 32'(cyc), 32'(e.cyc));
        if (e.rd) chk("b_rdata", e.src ? b_data_rd : b_inst_rd, e.data);
      end
    end
  end

  // One clock of stimulus; g = expected grant (0 none, 1 inst, 2 data)
  task automatic step(input bit sel, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [3:0] ds, input logic [31:0] da,
                      input logic [31:0] dw, input int g);
    resp_t       e;
    logic [31:0] addr;
    logic [1:0]  aok;
    @(posedge clock);
    #1;
    reset_ = 1'b1;
    if (!sel) begin
      a_inst_req = ir; a_inst_addr = ia; a_data_req = dr; a_data_ws = ds; a_data_addr = da; a_data_wd = dw;
    end else begin
      b_inst_req = ir; b_inst_addr = ia; b_data_req = dr; b_data_ws = ds; b_data_addr = da; b_data_wd = dw;
    end
    addr = (g == 2) ? da : ia;
    if (g != 0) begin
      e.src  = (g == 2);
      e.rd   = (g == 1) || (ds == 4'h0);
      e.data = expect_rd(sel, addr);
      e.cyc  = cyc + (sel ? 3 : 1);
      if (sel) qb.push_back(e); else qa.push_back(e);
      if (!sel && g == 2 && ds != 4'h0) begin
        exp_a[idx(da)] = merge(expect_rd(0, da), dw, ds);
        ew_a[idx(da)]  = 1'b1;
      end
    end
    @(negedge clock);
    aok = sel ? {b_inst_addr_ok, b_data_addr_ok} : {a_inst_addr_ok, a_data_addr_ok};
    chk("addr_ok", {30'd0, aok}, (g == 1) ? 32'd2 : (g == 2) ? 32'd1 : 32'd0);
    chk("ram_enabled", {31'd0, sel ? b_ram_en : a_ram_en}, {31'd0, g != 0});
    chk("ram_write_strobe", {28'd0, sel ? b_ram_ws : a_ram_ws}, (g == 2) ? {28'd0, ds} : 32'd0);
    if (g != 0) chk("ram_address", sel ? b_ram_addr : a_ram_addr, addr);
    if (g == 2 && ds != 4'h0) chk("ram_write_data", sel ? b_ram_wd : a_ram_wd, dw);
  endtask

  initial begin
    reset_ = 1'b0;
    a_inst_req = 1'b1; a_inst_ws = 4'h0; a_inst_addr = 32'h1000; a_inst_wd = 32'h0;
    a_data_req = 1'b1; a_data_ws = 4'h0; a_data_addr = 32'h3000; a_data_wd = 32'h0;
    b_inst_req = 1'b0; b_inst_ws = 4'h0; b_inst_addr = 32'h0; b_inst_wd = 32'h0;
    b_data_req = 1'b0; b_data_ws = 4'h0; b_data_addr = 32'h0; b_data_wd = 32'h0;

    // Reset held with both requests pending
    repeat (2) @(negedge clock);
    chk("rst_ok_flags", {27'd0, a_inst_addr_ok, a_data_addr_ok, a_inst_data_ok, a_data_data_ok, a_ram_en}, 32'd0);
    chk("rst_ram_strobe", {28'd0, a_ram_ws}, 32'd0);

    // Release: data granted in the first cycle out of reset
    step(0, 1, 32'h1000, 1, 4'h0, 32'h3000, 32'h0, 2);
    // Single instruction read of 0x1000
    step(0, 1, 32'h1000, 0, 4'h0, 32'h0, 32'h0, 1);
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    // Data write then read-back
    step(0, 0, 32'h0, 1, 4'hF, 32'h2000, 32'h1234_5678, 2);
    step(0, 0, 32'h0, 1, 4'h0, 32'h2000, 32'h0, 2);
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    // Both held high: D,D,D,D,I repeating
    for (int i = 0; i < 10; i++)
      step(0, 1, 32'h1000, 1, 4'h0, 32'h3000, 32'h0, (i % 5 == 4) ? 1 : 2);
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Latency 3: alternating instruction/data reads back to back
    for (int i = 0; i < 6; i++)
      step(1, (i % 2 == 0), 32'h40 + 32'(4 * i), (i % 2 == 1), 4'h0, 32'h80 + 32'(4 * i), 32'h0,
           (i % 2 == 0) ? 1 : 2);
    for (int i = 0; i < 4; i++) step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Two reads in flight, then reset pulse: their responses must never appear
    step(1, 1, 32'h48, 0, 4'h0, 32'h0, 32'h0, 1);
    step(1, 0, 32'h0, 1, 4'h0, 32'h88, 32'h0, 2);
    @(posedge clock);
    #1;
    reset_ = 1'b0;
    b_inst_req = 1'b0;
    b_data_req = 1'b0;
    qb.delete();
    @(negedge clock);
    chk("midrst_b_flags", {27'd0, b_inst_addr_ok, b_data_addr_ok, b_inst_data_ok, b_data_data_ok, b_ram_en}, 32'd0);
    step(1, 1, 32'h4C, 0, 4'h0, 32'h0, 32'h0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    chk("a_drained", 32'(qa.size()), 32'd0);
    chk("b_drained", 32'(qb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
